vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz board clock. Divides the clock by 4 to a 25 MHz pixel enable. Runs the horizontal and vertical pixel counters and produces hSync, vSync and bright. Sits directly upstream of the pixel-colour/block controller, which consumes hCount, vCount and bright; hSync/vSync go to the VGA pins.

Parameters:
CLK_DIV, 4, clk cycles per pixel (>=2)
H_TOTAL, 800, pixels per line including blanking
V_TOTAL, 525, lines per frame including blanking
H_SYNC, 96, hSync low width in pixels (hCount 0..H_SYNC-1)
V_SYNC, 2, vSync low width in lines (vCount 0..V_SYNC-1)
H_ACT_START, 144, first visible hCount
H_ACT_END, 783, last visible hCount (inclusive)
V_ACT_START, 35, first visible vCount
V_ACT_END, 514, last visible vCount (inclusive)

Ports:
clk  input  1  100 MHz system clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
pix_en  output  1  one-clk pulse every CLK_DIV clks; marks pixel advance
hCount  output  10  horizontal pixel counter, 0..H_TOTAL-1
vCount  output  10  vertical line counter, 0..V_TOTAL-1
hSync  output  1  horizontal sync, active low
vSync  output  1  vertical sync, active low
bright  output  1  high only inside the visible window
line_tick  output  1  one-clk pulse when hCount wraps to 0
frame_tick  output  1  one-clk pulse when hCount and vCount both wrap to 0

Behaviour:
- Reset (async, rst=1): div counter=0, hCount=0, vCount=0, pix_en=0, hSync=0, vSync=0, bright=0, line_tick=0, frame_tick=0. Outputs hold while rst is high. Counting restarts on the first clk edge after release.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en is registered and high during the cycle after div==CLK_DIV-1, giving exactly 1 clk high in every CLK_DIV clks. First pix_en occurs CLK_DIV clks after reset release.
- Counters advance on the clk edge where pix_en==1:
  - hCount==H_TOTAL-1 -> hCount=0, and vCount advances.
  - Otherwise hCount+1.
  - vCount wraps from V_TOTAL-1 to 0.
  - Counters never exceed TOTAL-1.
- hSync, vSync and bright are registered and update on the same edge as the counters, computed from the new counter values. There is zero cycle skew between the counters and the decodes.
  - hSync = (hCount >= H_SYNC)
  - vSync = (vCount >= V_SYNC)
  - bright = H_ACT_START<=hCount<=H_ACT_END and V_ACT_START<=vCount<=V_ACT_END
- line_tick is high for the single clk following the edge on which hCount became 0. frame_tick is high for the single clk following the edge on which both counters became 0. Both ticks fire together at frame wrap.
- Widths: counters are 10-bit unsigned, and compares are unsigned. Parameters must fit in 10 bits; no saturation logic.
- Reset mid-frame: all state clears immediately (asynchronous). No partial line or frame is completed.

Optional Feature:
FRAME_COUNT_EN
- Defined: adds output port frame_cnt (8 bits). It resets to 0, increments on the same edge that raises frame_tick, and wraps 255->0. The game logic uses it as a slow animation/debounce timebase.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Release rst, run 20 clks -> pix_en first high 4 clks after release, then period exactly 4 clks with 1-clk width; hCount=0..4 over that span.
- Run one full line -> hSync low for hCount 0..95 (384 clks), high for hCount 96..799. line_tick pulses once when hCount 799->0, and vCount increments 0->1 on the same edge.
- Run one full frame -> vSync low only for vCount 0..1. bright high for exactly 640x480 = 307200 pix_en cycles. First bright at (144,35), last at (783,514).
- Frame wrap at (799,524) -> next pix_en edge gives (0,0). line_tick and frame_tick are both high for exactly one clk. Frame length = 800x525x4 = 1,680,000 clks.
- Assert rst asynchronously mid-clk at hCount=400, vCount=200 -> all outputs 0 before the next clk edge. After release, timing restarts from (0,0) as in the first scenario.
- With FRAME_COUNT_EN defined, run 257 frames -> frame_cnt steps 0,1,…,255,0,1, changing only on frame_tick edges.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the VGA timing generator to its consumers.
// FRAME_COUNT_EN adds the 8-bit frame_cnt timebase.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       line_tick;
  logic       frame_tick;
`ifdef FRAME_COUNT_EN
  logic [7:0] frame_cnt;
  modport master (output pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick, frame_cnt);
  modport slave  (input  pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick, frame_cnt);
`else
  modport master (output pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick);
  modport slave  (input  pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing (pixel enable, counters, syncs, bright, ticks).
// FRAME_COUNT_EN adds a wrapping 8-bit frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_SYNC      = 96,
  parameter int V_SYNC      = 2,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga_o
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS = 10'(H_SYNC);
  localparam logic [9:0] VS = 10'(V_SYNC);
  localparam logic [9:0] HA0 = 10'(H_ACT_START);
  localparam logic [9:0] HA1 = 10'(H_ACT_END);
  localparam logic [9:0] VA0 = 10'(V_ACT_START);
  localparam logic [9:0] VA1 = 10'(V_ACT_END);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic pix_en_q, pix_en_d, hs_q, hs_d, vs_q, vs_d, br_q, br_d, lt_q, lt_d, ft_q, ft_d;
  logic h_wrap, v_wrap;
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d = (div_q == DIV_LAST);
    h_wrap   = (h_q == H_LAST);
    v_wrap   = (v_q == V_LAST);
    h_d      = pix_en_q ? (h_wrap ? '0 : h_q + 10'd1) : h_q;
    v_d      = (pix_en_q && h_wrap) ? (v_wrap ? '0 : v_q + 10'd1) : v_q;
    lt_d     = pix_en_q && h_wrap;
    ft_d     = lt_d && v_wrap;
    // decodes use next-state counters so they line up with the counters they describe
    hs_d     = (h_d >= HS);
    vs_d     = (v_d >= VS);
    br_d     = (h_d >= HA0) && (h_d <= HA1) && (v_d >= VA0) && (v_d <= VA1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      br_q     <= 1'b0;
      lt_q     <= 1'b0;
      ft_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      br_q     <= br_d;
      lt_q     <= lt_d;
      ft_q     <= ft_d;
    end
  end
`ifdef FRAME_COUNT_EN
  logic [7:0] fc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fc_q <= '0;
    else if (ft_d) fc_q <= fc_q + 8'd1;
  end
  assign vga_o.frame_cnt = fc_q;
`endif
  assign vga_o.pix_en     = pix_en_q;
  assign vga_o.hCount     = h_q;
  assign vga_o.vCount     = v_q;
  assign vga_o.hSync      = hs_q;
  assign vga_o.vSync      = vs_q;
  assign vga_o.bright     = br_q;
  assign vga_o.line_tick  = lt_q;
  assign vga_o.frame_tick = ft_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench; expected raster state is derived from elapsed clocks since reset.
// Shrunken raster keeps whole frames (and the 257-frame counter wrap) within a short run.
module tb_vga_timing_gen;
  localparam int D = 2, HT = 10, VT = 6, HS = 2, VS = 2;
  localparam int HA0 = 3, HA1 = 8, VA0 = 2, VA1 = 4;
  typedef logic [33:0] obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int t = 0;
  obs_t q[$];
  vga_timing_gen_if vga();
  vga_timing_gen #(
    .CLK_DIV(D), .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
    .H_ACT_START(HA0), .H_ACT_END(HA1), .V_ACT_START(VA0), .V_ACT_END(VA1)
  ) dut (.clk(clk), .rst(rst), .vga_o(vga.master));
  always #5 clk = ~clk;
  // t clocks after release: n pixel advances have happened, raster position is n in row-major order
  function automatic obs_t model(int tc);
    int n, h, v;
    logic pe, adv, hs, vs, br, lt, ft;
    logic [7:0] fc;
    n   = (tc > 0) ? (tc - 1) / D : 0;
    pe  = (tc >= D) && (tc % D == 0);
    adv = (tc > D) && ((tc - 1) % D == 0);
    h   = n % HT;
    v   = (n / HT) % VT;
    hs  = (h >= HS);
    vs  = (v >= VS);
    br  = (h >= HA0) && (h <= HA1) && (v >= VA0) && (v <= VA1);
    lt  = adv && (h == 0);
    ft  = lt && (v == 0);
`ifdef FRAME_COUNT_EN
    fc  = 8'((n / (HT * VT)) % 256);
`else
    fc  = 8'd0;
`endif
    return {pe, 10'(h), 10'(v), hs, vs, br, lt, ft, fc};
  endfunction
  function automatic obs_t observe();
    logic [7:0] fc;
`ifdef FRAME_COUNT_EN
    fc = vga.frame_cnt;
`else
    fc = 8'd0;
`endif
    return {vga.pix_en, vga.hCount, vga.vCount, vga.hSync, vga.vSync, vga.bright, vga.line_tick, vga.frame_tick, fc};
  endfunction
  always @(posedge clk) begin
    t = rst ? 0 : t + 1;
    q.push_back(model(t));
  end
  always @(negedge clk) begin
    obs_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = observe();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL raster t=%0d act=%h exp=%h", t, a, e);
      end
    end
  end
  task automatic check_async_zero();
    obs_t a;
    a = observe();
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL async_reset act=%h exp=0", a);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) begin
      repeat ($urandom_range(40, 800)) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_async_zero();
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst = 1'b0;
    end
    repeat (257 * HT * VT * D + 50) @(negedge clk);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
